// File: rtl/rom_reader.sv
// Burst reader: walks a range of a combinational ROM and streams the words
// out through a 2-entry FIFO with a valid/ready handshake.
module rom_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int WORDS      = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH+1:0] WORDS_L   = (ADDR_WIDTH+2)'(WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   REM_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   REM_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [ADDR_WIDTH:0]     rem_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    // FIFO kept as head/tail registers so the stream outputs come straight from flops
    logic                    head_v_r;
    logic                    tail_v_r;
    logic [DATA_WIDTH-1:0]   head_data_r;
    logic [DATA_WIDTH-1:0]   tail_data_r;
    logic                    head_last_r;
    logic                    tail_last_r;

    logic                    pop_s;
    logic                    push_s;
    logic                    push_last_s;
    logic [ADDR_WIDTH+1:0]   end_addr_s;

    // Handshake decode and burst range computation
    always_comb begin
        pop_s       = head_v_r & ready_i;
        push_s      = (state_r == S_FETCH) & (~(head_v_r & tail_v_r) | pop_s);
        push_last_s = (rem_r == REM_ONE);
        end_addr_s  = {2'b00, base_addr_i} + {1'b0, len_i};
    end

    // Two-entry FIFO: pop promotes tail to head, push fills the first free slot
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_v_r    <= 1'b0;
            tail_v_r    <= 1'b0;
            head_data_r <= {DATA_WIDTH{1'b0}};
            tail_data_r <= {DATA_WIDTH{1'b0}};
            head_last_r <= 1'b0;
            tail_last_r <= 1'b0;
        end else if (pop_s) begin
            if (tail_v_r) begin
                head_data_r <= tail_data_r;
                head_last_r <= tail_last_r;
                if (push_s) begin
                    tail_data_r <= rom_data_i;
                    tail_last_r <= push_last_s;
                end else begin
                    tail_v_r    <= 1'b0;
                end
            end else if (push_s) begin
                head_data_r <= rom_data_i;
                head_last_r <= push_last_s;
            end else begin
                head_v_r    <= 1'b0;
            end
        end else if (push_s) begin
            if (!head_v_r) begin
                head_v_r    <= 1'b1;
                head_data_r <= rom_data_i;
                head_last_r <= push_last_s;
            end else begin
                tail_v_r    <= 1'b1;
                tail_data_r <= rom_data_i;
                tail_last_r <= push_last_s;
            end
        end else begin
            head_v_r    <= head_v_r;
        end
    end

    // Burst control FSM with registered status pulses
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= S_IDLE;
            addr_r  <= ADDR_ZERO;
            rem_r   <= REM_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r <= pop_s & head_last_r;
            err_r  <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        if (len_i == REM_ZERO) begin
                            done_r <= 1'b1;
                        end else if (end_addr_s > WORDS_L) begin
                            err_r <= 1'b1;
                        end else begin
                            state_r <= S_FETCH;
                            busy_r  <= 1'b1;
                            addr_r  <= base_addr_i;
                            rem_r   <= len_i;
                        end
                    end
                end
                S_FETCH: begin
                    if (push_s) begin
                        addr_r <= addr_r + ADDR_ONE;
                        rem_r  <= rem_r - REM_ONE;
                        if (push_last_s) begin
                            state_r <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pop_s && !tail_v_r) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr_o = addr_r;
    assign data_o     = head_data_r;
    assign last_o     = head_last_r;
    assign valid_o    = head_v_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign err_o      = err_r;

endmodule
